dsp48_e2: RTL and testbench

DSP48_E2 -- requirements
Module: dsp48_e2

---
 rtl/dsp48_e2.sv | 98 +++++++++
 tb/tb_dsp48_e2.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dsp48_e2.sv
// dsp48_e2: pre-adder / multiplier / 4-input ALU slice with optional A/D, B, C, M, P pipeline registers.
// Define DSP48_E2_PATDET_EN to build the pattern detector; otherwise patterndetect is tied low.
module dsp48_e2 #(
    parameter int AREG = 0,
    parameter int BREG = 0,
    parameter int CREG = 0,
    parameter int MREG = 0,
    parameter int PREG = 0,
    parameter string USE_MULT = "NONE",
    parameter logic [47:0] RND = 48'h0,
    parameter logic [47:0] PATTERN = 48'h0,
    parameter logic [47:0] MASK = 48'h3fffffffffff
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic [29:0] a,
    input  logic [17:0] b,
    input  logic [47:0] c,
    input  logic [26:0] d,
    input  logic        carryin,
    input  logic [4:0]  inmode,
    input  logic [8:0]  opmode,
    input  logic [3:0]  alumode,
    output logic [47:0] p,
    output logic        carryout,
    output logic        patterndetect
);
    localparam bit MULT_ON = USE_MULT == "MULTIPLY";

    logic [29:0] a_r, a_s;
    logic [26:0] d_r, d_s, pre_a, pre_d, ad, mul_a;
    logic [17:0] b_r, b_s;
    logic [47:0] c_r, c_s, m_r, m_s, m_c, prod, p_r, pfb;
    logic [47:0] x, y, z, w;
    logic [48:0] s, z49, alu;
    logic        co_r;
    logic        unused_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r  <= '0;
            d_r  <= '0;
            b_r  <= '0;
            c_r  <= '0;
            m_r  <= '0;
            p_r  <= '0;
            co_r <= 1'b0;
        end else if (ce) begin
            a_r  <= a;
            d_r  <= d;
            b_r  <= b;
            c_r  <= c;
            m_r  <= m_c;
            p_r  <= alu[47:0];
            co_r <= alu[48];
        end
    end

    always_comb begin
        a_s   = AREG != 0 ? a_r : a;
        d_s   = AREG != 0 ? d_r : d;
        b_s   = BREG != 0 ? b_r : b;
        c_s   = CREG != 0 ? c_r : c;
        pre_d = inmode[2] ? d_s : 27'd0;
        pre_a = inmode[1] ? 27'd0 : a_s[26:0];
        ad    = inmode[3] ? pre_d - pre_a : pre_d + pre_a;
        mul_a = inmode[2] ? ad : a_s[26:0];
        prod  = 48'($signed(mul_a)) * 48'($signed(b_s));
        m_c   = MULT_ON ? prod : 48'd0;
        m_s   = MREG != 0 ? m_r : m_c;
        // P feedback only exists when the output register is present.
        pfb   = PREG != 0 ? p_r : 48'd0;
        x     = opmode[1:0] == 2'b00 ? 48'd0 : opmode[1:0] == 2'b01 ? m_s :
                opmode[1:0] == 2'b10 ? pfb : {a_s, b_s};
        y     = opmode[3:2] == 2'b10 ? {48{1'b1}} : opmode[3:2] == 2'b11 ? c_s : 48'd0;
        z     = opmode[6:4] == 3'b010 ? pfb : opmode[6:4] == 3'b011 ? c_s : 48'd0;
        w     = opmode[8:7] == 2'b00 ? 48'd0 : opmode[8:7] == 2'b01 ? pfb :
                opmode[8:7] == 2'b10 ? RND : c_s;
        s     = {1'b0, w} + {1'b0, x} + {1'b0, y} + 49'(carryin);
        z49   = {1'b0, z};
        alu   = alumode == 4'b0011 ? z49 - s :
                alumode == 4'b0001 ? s - z49 - 49'd1 :
                alumode == 4'b0010 ? ~(z49 + s) : z49 + s;
    end

    assign p         = PREG != 0 ? p_r : alu[47:0];
    assign carryout  = PREG != 0 ? co_r : alu[48];
    assign unused_in = ^{inmode[4], inmode[0]};

`ifdef DSP48_E2_PATDET_EN
    assign patterndetect = ((p ^ PATTERN) & ~MASK) == 48'd0;
`else
    logic unused_pat;
    assign unused_pat    = ^{PATTERN, MASK};
    assign patterndetect = 1'b0;
`endif
endmodule

// File: tb/tb_dsp48_e2.sv
// tb_dsp48_e2: randomized self-checking bench for dsp48_e2 in four build configurations.
module tb_dsp48_e2;
    localparam logic [47:0] RND0 = 48'h123456789abc;
    localparam logic [47:0] RND2 = 48'h000000800000;
    localparam logic [47:0] RND3 = 48'ha5a500005a5a;
    localparam logic [47:0] DMASK = 48'h3fffffffffff;
    localparam logic [47:0] MSK2 = 48'hffffffffff00;

    logic clk = 1'b0, rst_n = 1'b1, ce = 1'b0, carryin = 1'b0;
    logic [29:0] a = '0;
    logic [17:0] b = '0;
    logic [47:0] c = '0;
    logic [26:0] d = '0;
    logic [4:0]  inmode = '0;
    logic [8:0]  opmode = '0;
    logic [3:0]  alumode = '0;
    logic [47:0] p0, p1, p2, p3;
    logic        co0, co1, co2, co3, pd0, pd1, pd2, pd3;
    int errs = 0, checks = 0;

    // reference state for the pipelined builds
    logic [29:0] ra;
    logic [17:0] rb;
    logic [47:0] rc, rm, rp2, rp3;
    logic [26:0] rd;
    logic        rco2, rco3;

    always #5 clk = ~clk;

    dsp48_e2 #(.USE_MULT("MULTIPLY"), .RND(RND0)) u0 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .a(a), .b(b), .c(c), .d(d), .carryin(carryin),
        .inmode(inmode), .opmode(opmode), .alumode(alumode),
        .p(p0), .carryout(co0), .patterndetect(pd0));

    dsp48_e2 #(.USE_MULT("NONE")) u1 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .a(a), .b(b), .c(c), .d(d), .carryin(carryin),
        .inmode(inmode), .opmode(opmode), .alumode(alumode),
        .p(p1), .carryout(co1), .patterndetect(pd1));

    dsp48_e2 #(.PREG(1), .USE_MULT("MULTIPLY"), .RND(RND2), .PATTERN(48'h0), .MASK(MSK2)) u2 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .a(a), .b(b), .c(c), .d(d), .carryin(carryin),
        .inmode(inmode), .opmode(opmode), .alumode(alumode),
        .p(p2), .carryout(co2), .patterndetect(pd2));

    dsp48_e2 #(.AREG(1), .BREG(1), .CREG(1), .MREG(1), .PREG(1), .USE_MULT("MULTIPLY"),
               .RND(RND3)) u3 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .a(a), .b(b), .c(c), .d(d), .carryin(carryin),
        .inmode(inmode), .opmode(opmode), .alumode(alumode),
        .p(p3), .carryout(co3), .patterndetect(pd3));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint sx(longint v, int bits);
        longint m = (longint'(1) << bits) - 1;
        v = v & m;
        return v >= (longint'(1) << (bits - 1)) ? v - (longint'(1) << bits) : v;
    endfunction

    function automatic logic [47:0] mult_ref(logic [29:0] av, logic [17:0] bv, logic [26:0] dv);
        longint aa = inmode[1] ? 0 : longint'(av[26:0]);
        longint dd = inmode[2] ? longint'(dv) : 0;
        longint ad = sx(inmode[3] ? dd - aa : dd + aa, 27);
        longint op = inmode[2] ? ad : sx(longint'(av[26:0]), 27);
        return 48'(op * sx(longint'(bv), 18));
    endfunction

    function automatic logic [48:0] slice_ref(logic [29:0] av, logic [17:0] bv, logic [47:0] cv,
                                              logic [47:0] mv, logic [47:0] pf, logic [47:0] rnd);
        logic [47:0] x, y, z, w;
        longint s, zz, r;
        case (opmode[1:0]) 2'd0: x = '0; 2'd1: x = mv; 2'd2: x = pf; default: x = {av, bv}; endcase
        case (opmode[3:2]) 2'd2: y = '1; 2'd3: y = cv; default: y = '0; endcase
        case (opmode[6:4]) 3'd2: z = pf; 3'd3: z = cv; default: z = '0; endcase
        case (opmode[8:7]) 2'd0: w = '0; 2'd1: w = pf; 2'd2: w = rnd; default: w = cv; endcase
        s  = longint'(w) + longint'(x) + longint'(y) + longint'(carryin);
        zz = longint'(z);
        case (alumode)
            4'b0011: r = zz - s;
            4'b0001: r = -zz + s - 1;
            4'b0010: r = -(zz + s) - 1;
            default: r = zz + s;
        endcase
        return 49'(r);
    endfunction

    function automatic logic pd_ref(logic [47:0] pv, logic [47:0] pat, logic [47:0] msk);
`ifdef DSP48_E2_PATDET_EN
        return ((pv ^ pat) & ~msk) == 48'd0;
`else
        return 1'b0 & ^{pv, pat, msk};
`endif
    endfunction

    task automatic clear_model();
        ra = '0; rb = '0; rc = '0; rd = '0; rm = '0;
        rp2 = '0; rco2 = 1'b0; rp3 = '0; rco3 = 1'b0;
    endtask

    task automatic check_all();
        logic [48:0] e;
        e = slice_ref(a, b, c, mult_ref(a, b, d), 48'd0, RND0);
        check("u0_p", p0, e[47:0]);
        check("u0_co", co0, e[48]);
        check("u0_pd", pd0, pd_ref(e[47:0], 48'h0, DMASK));
        e = slice_ref(a, b, c, 48'd0, 48'd0, 48'd0);
        check("u1_p", p1, e[47:0]);
        check("u1_co", co1, e[48]);
        check("u2_p", p2, rp2);
        check("u2_co", co2, rco2);
        check("u2_pd", pd2, pd_ref(rp2, 48'h0, MSK2));
        check("u3_p", p3, rp3);
        check("u3_co", co3, rco3);
        check("u3_pd", pd3, pd_ref(rp3, 48'h0, DMASK));
    endtask

    task automatic step();
        logic [48:0] e2, e3;
        @(posedge clk);
        if (rst_n && ce) begin
            e2 = slice_ref(a, b, c, mult_ref(a, b, d), rp2, RND2);
            e3 = slice_ref(ra, rb, rc, rm, rp3, RND3);
            rm = mult_ref(ra, rb, rd);
            rp2 = e2[47:0]; rco2 = e2[48];
            rp3 = e3[47:0]; rco3 = e3[48];
            ra = a; rb = b; rc = c; rd = d;
        end
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        clear_model();
        check("rst_p2", p2, 48'd0);
        check("rst_p3", p3, 48'd0);
        check("rst_co3", co3, 1'b0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        clear_model();
        #2;
        check("init_p2", p2, 48'd0);
        check("init_co2", co2, 1'b0);
        check("init_p3", p3, 48'd0);
        rst_n = 1'b1;
        // combinational directed cases
        opmode = 9'b000110011; alumode = 4'b0000; inmode = 5'd0; carryin = 1'b0;
        a = 30'd0; b = 18'd5; c = 48'd7;
        #1 check("add_small", p0, 48'd12);
        check("add_small_co", co0, 1'b0);
        a = 30'd1; b = 18'd0; c = 48'd0;
        #1 check("ab_concat", p0, 48'h40000);
        a = 30'h3fffffff; b = 18'h3ffff; c = 48'd1;
        #1 check("wrap_p", p0, 48'd0);
        check("wrap_co", co0, 1'b1);
        opmode = 9'b000000001; a = 30'h07fffffd; b = 18'd4; c = 48'd0;
        #1 check("mult_neg", p0, 48'hfffffffffff4);
        check("mult_none", p1, 48'd0);
        check_all();
        // P accumulation, hold and async clear
        @(posedge clk); #1;
        ce = 1'b1; opmode = 9'b000100011; a = 30'd0; b = 18'd1; c = 48'd0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("acc", p2, 48'(i));
            check_all();
        end
        ce = 1'b0;
        step(); step();
        check("acc_hold", p2, 48'd3);
        check_all();
        pulse_reset();
        check("post_rst_p2", p2, 48'd0);
        // pattern detector
        ce = 1'b1; b = 18'h100;
        step();
        check("pat_val", p2, 48'h100);
`ifdef DSP48_E2_PATDET_EN
        check("pat_hit", pd2, 1'b1);
`else
        check("pat_off", pd2, 1'b0);
`endif
        b = 18'd1;
        step();
        check("pat_val2", p2, 48'h101);
        check("pat_miss", pd2, 1'b0);
        check_all();
        // random traffic
        for (int i = 0; i < 600; i++) begin
            a = 30'($urandom); b = 18'($urandom); c = {16'($urandom), 32'($urandom)};
            d = 27'($urandom); inmode = 5'($urandom); opmode = 9'($urandom);
            alumode = 4'($urandom); carryin = 1'($urandom);
            ce = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 49) == 0) pulse_reset();
            #1 check_all();
            step();
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
